// File: rtl/rns_modulus_seq_pkg.sv
// rns_modulus_seq_pkg: FSM state encodings and counter sizing shared by the
// modulo sequencer.
package rns_modulus_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed for a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rns_mod_step.sv
// rns_mod_step: one restoring-division step. The partial remainder has already
// had the next dividend bit shifted in; subtract the modulus if it fits.
module rns_mod_step #(
    parameter int MW = 3
) (
    input  logic [MW:0]   r_in,
    input  logic [MW-1:0] modulus,
    output logic [MW-1:0] r_next,
    output logic          qbit
);

    logic [MW-1:0] diff;

    // The true difference is always below the modulus, so MW bits are enough.
    always_comb begin
        qbit   = (r_in >= {1'b0, modulus});
        diff   = r_in[MW-1:0] - modulus;
        r_next = qbit ? diff : r_in[MW-1:0];
    end

endmodule

// File: rtl/rns_modulus_seq.sv
// rns_modulus_seq: iterative restoring modulo unit, remainder = dividend mod
// modulus, one dividend bit per clock, valid/ready on both sides.
// Optional feature macro: RNS_MOD_QUOTIENT_EN adds the out_quotient port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready high
// ST_BUSY | shifting dividend bits through the step (skipped in effect for m=0)
// ST_DONE | result registered and held, out_valid high until out_ready
module rns_modulus_seq
    import rns_modulus_seq_pkg::*;
#(
    parameter int DW = 6,
    parameter int MW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_dividend,
    input  logic [MW-1:0] in_modulus,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_remainder,
    output logic          out_div_zero
`ifdef RNS_MOD_QUOTIENT_EN
    ,
    output logic [DW-1:0] out_quotient
`endif
);

    localparam int CW = cnt_width(DW);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] dvd_q;
    logic [MW-1:0] mod_q;
    logic [MW-1:0] rem_q;
    logic          dz_q;
    logic [MW:0]   r_shift;
    logic [MW-1:0] r_next;
    logic          qbit;
    logic          accept;
    logic          last;
`ifdef RNS_MOD_QUOTIENT_EN
    logic [DW-1:0] quo_q;
`else
    logic          unused_qbit;
    assign unused_qbit = qbit;
`endif

    assign r_shift   = {rem_q, dvd_q[DW-1]};
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt_q == CW'(DW));

    rns_mod_step #(.MW(MW)) u_step (
        .r_in    (r_shift),
        .modulus (mod_q),
        .r_next  (r_next),
        .qbit    (qbit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_BUSY;
            ST_BUSY: if (last)     state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, iteration and result registration. A zero modulus
    // starts the counter one short of the end so the result appears after
    // two cycles, with the iteration frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            dvd_q         <= '0;
            mod_q         <= '0;
            rem_q         <= '0;
            dz_q          <= 1'b0;
            out_remainder <= '0;
            out_div_zero  <= 1'b0;
`ifdef RNS_MOD_QUOTIENT_EN
            quo_q         <= '0;
            out_quotient  <= '0;
`endif
        end else if (accept) begin
            dvd_q <= in_dividend;
            mod_q <= in_modulus;
            rem_q <= '0;
            dz_q  <= (in_modulus == '0);
            cnt_q <= (in_modulus == '0) ? CW'(DW - 1) : '0;
`ifdef RNS_MOD_QUOTIENT_EN
            quo_q <= '0;
`endif
        end else if (state_q == ST_BUSY) begin
            if (!last) begin
                cnt_q <= cnt_q + CW'(1);
                if (!dz_q) begin
                    rem_q <= r_next;
                    dvd_q <= {dvd_q[DW-2:0], 1'b0};
`ifdef RNS_MOD_QUOTIENT_EN
                    quo_q <= {quo_q[DW-2:0], qbit};
`endif
                end
            end else begin
                out_remainder <= dz_q ? dvd_q[MW-1:0] : rem_q;
                out_div_zero  <= dz_q;
`ifdef RNS_MOD_QUOTIENT_EN
                out_quotient  <= dz_q ? '0 : quo_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rns_modulus_seq.sv
// tb_rns_modulus_seq: directed checks on a DW=6/MW=3 instance and a random
// back-to-back run on a DW=16/MW=8 instance, both scoreboarded.
module tb_rns_modulus_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       iv, ir, ov, ordy, dz;
    logic [5:0] dvd;
    logic [2:0] md, rem;
`ifdef RNS_MOD_QUOTIENT_EN
    logic [5:0] quo;
`endif

    logic        iv16, ir16, ov16, ordy16, dz16;
    logic [15:0] dvd16;
    logic [7:0]  md16, rem16;
`ifdef RNS_MOD_QUOTIENT_EN
    logic [15:0] quo16;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] rem;
        logic        dz;
        logic [15:0] quo;
    } exp_t;

    exp_t sb6[$];
    exp_t sb16[$];

    rns_modulus_seq #(.DW(6), .MW(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (iv),
        .in_ready      (ir),
        .in_dividend   (dvd),
        .in_modulus    (md),
        .out_valid     (ov),
        .out_ready     (ordy),
        .out_remainder (rem),
        .out_div_zero  (dz)
`ifdef RNS_MOD_QUOTIENT_EN
        ,
        .out_quotient  (quo)
`endif
    );

    rns_modulus_seq #(.DW(16), .MW(8)) dut16 (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (iv16),
        .in_ready      (ir16),
        .in_dividend   (dvd16),
        .in_modulus    (md16),
        .out_valid     (ov16),
        .out_ready     (ordy16),
        .out_remainder (rem16),
        .out_div_zero  (dz16)
`ifdef RNS_MOD_QUOTIENT_EN
        ,
        .out_quotient  (quo16)
`endif
    );

    function automatic exp_t model(input logic [15:0] d, input logic [15:0] m, input int mw);
        exp_t e;
        if (m == 16'd0) begin
            e.rem = d & ((16'd1 << mw) - 16'd1);
            e.dz  = 1'b1;
            e.quo = 16'd0;
        end else begin
            e.rem = d % m;
            e.dz  = 1'b0;
            e.quo = d / m;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on the small instance: push expectation, wait for accept,
    // measure latency, hold back-pressure for 'hold' cycles, then consume.
    task automatic op6(input logic [5:0] d, input logic [2:0] m, input int exp_lat, input int hold);
        exp_t e;
        int   n;
        int   lat;
        sb6.push_back(model({10'd0, d}, {13'd0, m}, 3));
        @(negedge clk);
        dvd  = d;
        md   = m;
        iv   = 1'b1;
        ordy = 1'b0;
        n = 0;
        while (!ir && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 50, 1'b1);
        @(posedge clk);
        #1 iv = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov && lat < 100);
        if (exp_lat > 0) check("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            iv  = 1'b1;
            dvd = ~d;
            check("hold_valid", ov, 1'b1);
            check("hold_in_ready", ir, 1'b0);
            check("hold_remainder", rem, sb6[0].rem);
        end
        @(negedge clk);
        iv   = 1'b0;
        ordy = 1'b1;
        check("sb6_nonempty", sb6.size() > 0, 1'b1);
        e = sb6.pop_front();
        check("out_valid", ov, 1'b1);
        check("remainder", rem, e.rem);
        check("div_zero", dz, e.dz);
`ifdef RNS_MOD_QUOTIENT_EN
        check("quotient", quo, e.quo);
`endif
        @(posedge clk);
        #1 ordy = 1'b0;
        check("post_valid", ov, 1'b0);
        check("post_ready", ir, 1'b1);
    endtask

    localparam int NRAND = 40;

    initial begin
        int recv;
        int sent;

        rst_n = 1'b0;
        iv = 1'b0; ordy = 1'b0; dvd = '0; md = '0;
        iv16 = 1'b0; ordy16 = 1'b0; dvd16 = '0; md16 = '0;
        #12;
        check("rst_in_ready", ir, 1'b1);
        check("rst_out_valid", ov, 1'b0);
        check("rst_remainder", rem, 3'd0);
        check("rst_div_zero", dz, 1'b0);
        check("rst16_in_ready", ir16, 1'b1);
`ifdef RNS_MOD_QUOTIENT_EN
        check("rst_quotient", quo, 6'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        op6(6'd45, 3'd5, 7, 0);
        op6(6'd50, 3'd7, 7, 0);
        op6(6'd63, 3'd7, 7, 0);
        op6(6'd2,  3'd6, 7, 0);
        op6(6'd45, 3'd0, 2, 0);
        op6(6'd50, 3'd3, 7, 10);

        // Reset in the middle of 63 mod 5.
        @(negedge clk);
        dvd = 6'd63;
        md  = 3'd5;
        iv  = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", ov, 1'b0);
        check("midrst_in_ready", ir, 1'b1);
        check("midrst_remainder", rem, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_in_ready", ir, 1'b1);
        check("after_rst_out_valid", ov, 1'b0);
        op6(6'd11, 3'd4, 7, 0);

        // Random back-to-back traffic on the wide instance.
        recv = 0;
        sent = 0;
        fork
            begin
                for (int k = 0; k < NRAND; k++) begin
                    logic [15:0] d;
                    logic [7:0]  m;
                    int          w;
                    d = 16'($urandom);
                    m = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                    @(negedge clk);
                    dvd16 = d;
                    md16  = m;
                    iv16  = 1'b1;
                    w = 0;
                    while (!ir16 && w < 500) begin
                        @(negedge clk);
                        w++;
                    end
                    check("rand_accept_wait", w < 500, 1'b1);
                    sb16.push_back(model(d, {8'd0, m}, 8));
                    sent++;
                    @(posedge clk);
                    #1 iv16 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            begin
                int cyc;
                exp_t e;
                cyc = 0;
                while (recv < NRAND && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    ordy16 = ($urandom_range(0, 3) != 0);
                    if (ov16 && ordy16) begin
                        check("rand_sb_nonempty", sb16.size() > 0, 1'b1);
                        if (sb16.size() > 0) begin
                            e = sb16.pop_front();
                            check("rand_remainder", rem16, e.rem[7:0]);
                            check("rand_div_zero", dz16, e.dz);
`ifdef RNS_MOD_QUOTIENT_EN
                            check("rand_quotient", quo16, e.quo);
`endif
                        end
                        recv++;
                    end
                end
                check("rand_cycle_budget", cyc < 20000, 1'b1);
            end
        join
        @(negedge clk);
        ordy16 = 1'b0;
        check("rand_sent", sent, NRAND);
        check("rand_recv", recv, NRAND);
        check("rand_sb_drained", sb16.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
